multicycle_controller: RTL

Main control unit for the multicycle RV32I core: a Moore FSM that sequences the shared PC/IR/ALU/memory datapath one micro-step per clock, plus combinational ALU and immediate decoders. It replaces the single-cycle decoder in the top module. The core keeps its existing `clk`/`reset` and memory-write interface, so the infinite-`jal` stop condition still applies.

---
 rtl/multicycle_controller_if.sv | 36 +++
 rtl/multicycle_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle RV32I main controller and the datapath.
//
// Instruction fields and the ALU zero flag flow from the datapath into the
// controller. Register/mux enables, ALU and immediate selects and the debug
// state encoding flow back.
//   master : controller view (drives the control outputs)
//   slave  : datapath view   (drives instruction fields and Zero)
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, state
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegWrite, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control unit of the multicycle RV32I core.
//
// A Moore FSM sequences the shared PC/IR/ALU/memory datapath one micro-step
// per clock; the ALU decoder and the immediate decoder are combinational.
// The state register is the only storage.
//
// Ports:
//   clk   : core clock, rising edge
//   reset : synchronous, active-high; forces FETCH and holds all write
//           enables (PCWrite, IRWrite, MemWrite, RegWrite) low
//   ctrl  : multicycle_controller_if.master -- op/funct3/funct7b5/Zero in,
//           datapath controls and debug state out
//
// Parameter:
//   BRANCH_EXT : 1 = bne (funct3 001) inverts the branch condition,
//                0 = every branch behaves as beq
module multicycle_controller #(
  parameter bit BRANCH_EXT = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master ctrl
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t     state_r;
  state_t     next_state_s;
  state_t     dec_state_s;
  logic       pc_update_s;
  logic       branch_s;
  logic       taken_s;
  logic       ir_write_s;
  logic       mem_write_s;
  logic       reg_write_s;
  logic       adr_src_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
  logic [2:0] alu_control_s;
  logic [1:0] imm_src_s;

  // State register with synchronous reset into FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; the encodings 11..15 fall back to FETCH.
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH:    next_state_s = DECODE;
      DECODE: begin
        case (ctrl.op)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_R:         next_state_s = EXECUTER;
          OP_I:         next_state_s = EXECUTEI;
          OP_BR:        next_state_s = BRANCH;
          OP_JAL:       next_state_s = JAL;
          default:      next_state_s = FETCH;  // illegal op retires as a NOP
        endcase
      end
      MEMADR: begin
        if (ctrl.op == OP_LW) begin
          next_state_s = MEMREAD;
        end else begin
          next_state_s = MEMWRITE;
        end
      end
      MEMREAD:  next_state_s = MEMWB;
      EXECUTER: next_state_s = ALUWB;
      EXECUTEI: next_state_s = ALUWB;
      JAL:      next_state_s = ALUWB;
      MEMWB:    next_state_s = FETCH;
      MEMWRITE: next_state_s = FETCH;
      ALUWB:    next_state_s = FETCH;
      BRANCH:   next_state_s = FETCH;
      default:  next_state_s = FETCH;
    endcase
  end

  // While reset is held, the datapath sees the FETCH decode so the mux
  // selects are already settled for the first real fetch.
  always_comb begin
    if (reset) begin
      dec_state_s = FETCH;
    end else begin
      dec_state_s = state_r;
    end
  end

  // Moore output decode; anything not named in a state stays 0.
  always_comb begin
    pc_update_s  = 1'b0;
    branch_s     = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    result_src_s = 2'b00;
    alu_src_a_s  = 2'b00;
    alu_src_b_s  = 2'b00;
    alu_op_s     = 2'b00;
    case (dec_state_s)
      FETCH: begin
        ir_write_s   = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        pc_update_s  = 1'b1;
      end
      DECODE: begin
        alu_src_a_s = 2'b01;  // OldPC + imm: branch/jal target
        alu_src_b_s = 2'b01;
      end
      MEMADR: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
      end
      MEMREAD: begin
        adr_src_s = 1'b1;
      end
      MEMWB: begin
        result_src_s = 2'b01;
        reg_write_s  = 1'b1;
      end
      MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
      end
      EXECUTER: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b10;
      end
      EXECUTEI: begin
        alu_src_a_s = 2'b10;
        alu_src_b_s = 2'b01;
        alu_op_s    = 2'b10;
      end
      ALUWB: begin
        reg_write_s = 1'b1;
      end
      BRANCH: begin
        alu_src_a_s = 2'b10;
        alu_op_s    = 2'b01;
        branch_s    = 1'b1;
      end
      JAL: begin
        alu_src_a_s = 2'b01;  // OldPC + 4 becomes the link value
        alu_src_b_s = 2'b10;
        pc_update_s = 1'b1;
      end
      default: begin
        pc_update_s = 1'b0;
      end
    endcase
  end

  // ALU decoder: funct7b5 selects sub only for register-register ops,
  // so addi with imm[10]=1 still adds.
  always_comb begin
    alu_control_s = 3'b000;
    case (alu_op_s)
      2'b00: alu_control_s = 3'b000;
      2'b01: alu_control_s = 3'b001;
      2'b10: begin
        case (ctrl.funct3)
          3'b000: begin
            if (ctrl.op[5] & ctrl.funct7b5) begin
              alu_control_s = 3'b001;
            end else begin
              alu_control_s = 3'b000;
            end
          end
          3'b010:  alu_control_s = 3'b101;
          3'b110:  alu_control_s = 3'b011;
          3'b111:  alu_control_s = 3'b010;
          default: alu_control_s = 3'b000;
        endcase
      end
      default: alu_control_s = 3'b000;
    endcase
  end

  // Immediate format select, decoded from op in every state.
  always_comb begin
    imm_src_s = 2'b00;
    case (ctrl.op)
      OP_LW, OP_I: imm_src_s = 2'b00;
      OP_SW:       imm_src_s = 2'b01;
      OP_BR:       imm_src_s = 2'b10;
      OP_JAL:      imm_src_s = 2'b11;
      default:     imm_src_s = 2'b00;
    endcase
  end

  // bne inverts the zero test when the extension is enabled.
  assign taken_s = ctrl.Zero ^ (BRANCH_EXT & ctrl.funct3[0]);

  assign ctrl.PCWrite    = ~reset & (pc_update_s | (branch_s & taken_s));
  assign ctrl.IRWrite    = ~reset & ir_write_s;
  assign ctrl.MemWrite   = ~reset & mem_write_s;
  assign ctrl.RegWrite   = ~reset & reg_write_s;
  assign ctrl.AdrSrc     = adr_src_s;
  assign ctrl.ResultSrc  = result_src_s;
  assign ctrl.ALUSrcA    = alu_src_a_s;
  assign ctrl.ALUSrcB    = alu_src_b_s;
  assign ctrl.ALUControl = alu_control_s;
  assign ctrl.ImmSrc     = imm_src_s;
  assign ctrl.state      = state_r;

endmodule
